scroll_refresh_controller: RTL and testbench
============================================

// Module: scroll_refresh_controller
// PURPOSE
//  Drives the phase bus and message-window offset consumed by the 7-seg character decoder.
//  Steps a 4-bit refresh phase counter (4 sub-phases per digit, 4 digits) and drives active-low anodes.
//  Advances the 16-entry message window on an auto-scroll timer or a debounced button press.
//  Offset changes only at frame boundaries, so no frame mixes two windows.
// PARAMETERS
//  REFRESH_DIV      100000  clk cycles per phase step (>=1)
//  SCROLL_FRAMES    200     completed frames per auto-scroll step (>=1)
//  DEBOUNCE_CYCLES  500000  cycles btn must be stable to register (>=2)
// PORTS
//  clk                input   1  system clock, rising edge
//  reset              input   1  asynchronous, active-low; clears all state
//  scroll_en          input   1  1 = auto-scroll enabled
//  dir                input   1  0 = offset +1 per step, 1 = offset -1
//  btn                input   1  raw async push-button, 1 = pressed
//  counter            output  4  phase bus: [3:2] digit index, [1:0] sub-phase
//  active_mem_offset  output  4  message window start index
//  an                 output  4  anode enables, active-low
//  frame_tick         output  1  1-cycle pulse when counter wraps 15->0
// BEHAVIOUR
//  Reset (reset=0): counter=0, active_mem_offset=0, an=4'b1111, frame_tick=0, prescaler=0,
//   frame count=0, pending=0, conditioner state cleared. Takes effect immediately, mid-frame too.
//  Prescaler: counts 0..REFRESH_DIV-1; tick on terminal count; counter <= counter+1 on tick (4-bit wrap).
//  Anodes (registered, same edge as counter): an[k]=0 only when counter[3:2]==k and counter[1:0]==2'b11;
//   else 1. Sub-phases 00/01 = blanking, 10 = setup bus (char settles), 11 = digit lit.
//   Exactly one or zero anodes low at any time; never two.
//  Frame boundary = tick while counter==4'b1111; frame_tick=1 for that one cycle.
//  Auto-scroll: frame counter increments at each boundary while scroll_en=1; at SCROLL_FRAMES-1 it
//   clears and raises step_due. scroll_en=0 holds frame counter at 0.
//  Button: 2-FF synchroniser -> debounce (stable DEBOUNCE_CYCLES) -> rising-edge pulse -> sets pending.
//   Further presses before the boundary collapse into one step. Held button = one step only.
//  Step apply at frame boundary if step_due or pending: offset <= offset+1 (dir=0) or -1 (dir=1),
//   modulo 16 (15->0, 0->15). step_due and pending both true = ONE step; both cleared.
//  Press pulse on the same cycle as a boundary: applied at that boundary, not deferred.
//  dir sampled at the boundary cycle only. Offset never changes except on a boundary.
//  Latency: press stable DEBOUNCE_CYCLES+2 clks -> pending; pending -> offset change <= 16*REFRESH_DIV clks.
// STRUCTURE
//  Shared package: AN0..AN3_SETUP_BUS (4'b0010/0110/1010/1110), SUBPHASE_LIT=2'b11,
//   ANODES_OFF=4'b1111, PHASE_LAST=4'b1111.
//  Sub-module: button_conditioner (sync, debounce counter, edge detect; outputs press_pulse).
//  Top: prescaler, phase counter, anode decode register, frame counter, pending flag, offset register.
//  Counter widths: $clog2 of each parameter; no truncation warnings allowed.
// TESTING  (bench params: REFRESH_DIV=2, SCROLL_FRAMES=2, DEBOUNCE_CYCLES=4)
//  Reset release, scroll_en=0 -> counter 0..15 each held 2 clks; an=1110 only at counter 3,
//   1101 at 7, 1011 at 11, 0111 at 15; otherwise 1111; offset stays 0.
//  scroll_en=1,dir=0 -> offset 0->1 after 2nd frame_tick, ->2 after 4th; 15->0 wrap after 32 frames.
//  dir=1 from offset 0 -> first auto step gives 15.
//  btn high 3 clks then low -> no step; high 10 clks -> exactly one step at next boundary, none later.
//  Press registered in same frame an auto step is due -> offset advances by 1, not 2.
//  reset pulsed low at counter=9, offset=5 -> counter=0, offset=0, an=1111 same cycle, pending lost.

Source files
------------

// File: rtl/scroll_refresh_controller_pkg.sv
// Phase-bus encodings shared by the refresh controller and the 7-seg character decoder.
// Pure constants and a combinational helper; no latency, no backpressure.
package scroll_refresh_controller_pkg;

  localparam logic [3:0] AN0_SETUP_BUS = 4'b0010;
  localparam logic [3:0] AN1_SETUP_BUS = 4'b0110;
  localparam logic [3:0] AN2_SETUP_BUS = 4'b1010;
  localparam logic [3:0] AN3_SETUP_BUS = 4'b1110;
  localparam logic [1:0] SUBPHASE_LIT  = 2'b11;
  localparam logic [3:0] ANODES_OFF    = 4'b1111;
  localparam logic [3:0] PHASE_LAST    = 4'b1111;

  // A digit is lit only in the phase right after its bus-setup phase.
  function automatic logic [3:0] lit_anodes(input logic [3:0] phase);
    logic [3:0] an_val;
    an_val = ANODES_OFF;
    if (phase[1:0] == SUBPHASE_LIT) begin
      case (phase - 4'd1)
        AN0_SETUP_BUS: an_val = 4'b1110;
        AN1_SETUP_BUS: an_val = 4'b1101;
        AN2_SETUP_BUS: an_val = 4'b1011;
        AN3_SETUP_BUS: an_val = 4'b0111;
        default:       an_val = ANODES_OFF;
      endcase
    end
    return an_val;
  endfunction

endpackage

// File: rtl/scroll_refresh_controller_button_conditioner.sv
// Synchronises and debounces the raw button; press_pulse is a 1-cycle rising-edge strobe.
// Latency: press_pulse is high in the cycle before the edge DEBOUNCE_CYCLES+2 clks after btn rises; no backpressure.
module scroll_refresh_controller_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  logic          sync_q1, sync_q2, db_state;
  logic [DW-1:0] db_cnt;
  logic          settle;

  // The debounced state flips once the synchronised input has differed for DEBOUNCE_CYCLES cycles.
  assign settle      = (sync_q2 != db_state) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign press_pulse = settle && sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      db_state <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      if (sync_q2 == db_state) begin
        db_cnt <= '0;
      end else if (settle) begin
        db_state <= sync_q2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/scroll_refresh_controller.sv
// Steps the display phase bus and anodes, and moves the message window only at frame boundaries.
// Latency: anodes registered with the phase counter; offset moves at the first boundary after a request; no backpressure.
module scroll_refresh_controller
  import scroll_refresh_controller_pkg::*;
#(
  parameter int REFRESH_DIV     = 100000,
  parameter int SCROLL_FRAMES   = 200,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scroll_en,
  input  logic       dir,
  input  logic       btn,
  output logic [3:0] counter,
  output logic [3:0] active_mem_offset,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [PW-1:0] presc;
  logic [FW-1:0] frame_cnt;
  logic          tick, boundary, frame_last, step_due, press_pulse, pending, do_step;

  scroll_refresh_controller_button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_conditioner (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .press_pulse(press_pulse)
  );

  assign tick       = (presc == PW'(REFRESH_DIV - 1));
  assign boundary   = tick && (counter == PHASE_LAST);
  assign frame_tick = boundary;
  assign frame_last = (frame_cnt == FW'(SCROLL_FRAMES - 1));
  assign step_due   = boundary && scroll_en && frame_last;
  // A press strobe coinciding with the boundary is honoured there rather than waiting a frame.
  assign do_step    = boundary && (step_due || pending || press_pulse);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc             <= '0;
      counter           <= '0;
      an                <= ANODES_OFF;
      frame_cnt         <= '0;
      pending           <= 1'b0;
      active_mem_offset <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        counter <= counter + 4'd1;
        an      <= lit_anodes(counter + 4'd1);
      end
      if (!scroll_en)    frame_cnt <= '0;
      else if (boundary) frame_cnt <= frame_last ? '0 : frame_cnt + FW'(1);
      if (boundary)         pending <= 1'b0;
      else if (press_pulse) pending <= 1'b1;
      if (do_step) active_mem_offset <= dir ? active_mem_offset - 4'd1 : active_mem_offset + 4'd1;
    end
  end

endmodule

// File: tb/tb_scroll_refresh_controller.sv
// Directed bench for scroll_refresh_controller with REFRESH_DIV=2, SCROLL_FRAMES=2, DEBOUNCE_CYCLES=4.
module tb_scroll_refresh_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       scroll_en;
  logic       dir;
  logic       btn;
  logic [3:0] counter;
  logic [3:0] active_mem_offset;
  logic [3:0] an;
  logic       frame_tick;

  int nvec = 0;
  int nmis = 0;

  scroll_refresh_controller #(
    .REFRESH_DIV    (2),
    .SCROLL_FRAMES  (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .scroll_en        (scroll_en),
    .dir              (dir),
    .btn              (btn),
    .counter          (counter),
    .active_mem_offset(active_mem_offset),
    .an               (an),
    .frame_tick       (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_cnt;
    logic [3:0] exp_an;
    reset     = 1'b0;
    scroll_en = 1'b0;
    dir       = 1'b0;
    btn       = 1'b0;
    run(2);
    check("rst_counter", counter, 4'd0);
    check("rst_offset", active_mem_offset, 4'd0);
    check("rst_an", an, 4'b1111);
    check("rst_frame_tick", frame_tick, 1'b0);

    // Free-running refresh with scrolling off: each phase held 2 clks.
    reset = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      exp_cnt = 4'((n / 2) % 16);
      case (exp_cnt)
        4'd3:    exp_an = 4'b1110;
        4'd7:    exp_an = 4'b1101;
        4'd11:   exp_an = 4'b1011;
        4'd15:   exp_an = 4'b0111;
        default: exp_an = 4'b1111;
      endcase
      check("phase_counter", counter, exp_cnt);
      check("phase_an", an, exp_an);
      check("phase_frame_tick", frame_tick, ((n % 2) == 1) && (exp_cnt == 4'd15));
      check("phase_offset", active_mem_offset, 4'd0);
    end

    // Auto-scroll forward: one step every two frames.
    scroll_en = 1'b1;
    run(31);
    check("auto_ft1", frame_tick, 1'b1);
    check("auto_f1_pre", active_mem_offset, 4'd0);
    run(1);
    check("auto_f1", active_mem_offset, 4'd0);
    run(31);
    check("auto_ft2", frame_tick, 1'b1);
    check("auto_f2_pre", active_mem_offset, 4'd0);
    run(1);
    check("auto_f2", active_mem_offset, 4'd1);
    run(64);
    check("auto_f4", active_mem_offset, 4'd2);
    run(26 * 32);
    check("auto_f30", active_mem_offset, 4'd15);
    run(64);
    check("auto_wrap_f32", active_mem_offset, 4'd0);

    // Reverse direction from 0 wraps to 15.
    dir = 1'b1;
    run(32);
    check("rev_f1", active_mem_offset, 4'd0);
    run(32);
    check("rev_f2", active_mem_offset, 4'd15);
    scroll_en = 1'b0;
    dir       = 1'b0;

    // Short glitch: no step.
    btn = 1'b1;
    run(3);
    btn = 1'b0;
    run(29);
    check("glitch_f1", active_mem_offset, 4'd15);
    run(32);
    check("glitch_f2", active_mem_offset, 4'd15);

    // Valid press: exactly one step at the next boundary.
    btn = 1'b1;
    run(10);
    btn = 1'b0;
    run(21);
    check("press_pre_boundary", active_mem_offset, 4'd15);
    run(1);
    check("press_step", active_mem_offset, 4'd0);
    run(64);
    check("press_no_repeat", active_mem_offset, 4'd0);

    // Press lands in the frame where an auto step is due: single step.
    scroll_en = 1'b1;
    run(32);
    check("merge_fA", active_mem_offset, 4'd0);
    btn = 1'b1;
    run(10);
    btn = 1'b0;
    run(22);
    check("merge_fB", active_mem_offset, 4'd1);
    run(32);
    check("merge_fC", active_mem_offset, 4'd1);
    run(32);
    check("merge_fD", active_mem_offset, 4'd2);
    scroll_en = 1'b0;

    // Press strobe on the boundary cycle itself is applied there; held button steps once.
    run(26);
    btn = 1'b1;
    run(5);
    check("edge_pre", active_mem_offset, 4'd2);
    run(1);
    check("edge_step", active_mem_offset, 4'd3);
    run(4);
    btn = 1'b0;
    run(28);
    check("edge_no_defer", active_mem_offset, 4'd3);

    // Bring offset to 5, then reset mid-frame with a press pending.
    scroll_en = 1'b1;
    run(128);
    check("pre_reset_offset", active_mem_offset, 4'd5);
    scroll_en = 1'b0;
    btn = 1'b1;
    run(10);
    btn = 1'b0;
    run(8);
    check("pre_reset_counter", counter, 4'd9);
    reset = 1'b0;
    #1;
    check("midrst_counter", counter, 4'd0);
    check("midrst_offset", active_mem_offset, 4'd0);
    check("midrst_an", an, 4'b1111);
    check("midrst_frame_tick", frame_tick, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run(32);
    check("post_rst_counter", counter, 4'd0);
    check("post_rst_offset_f1", active_mem_offset, 4'd0);
    run(32);
    check("post_rst_pending_lost", active_mem_offset, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
